monopix_readout_ctrl: RTL and testbench

MONOPIX_READOUT_CTRL -- requirements
Module: monopix_readout_ctrl

---
 rtl/monopix_readout_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_monopix_readout_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/monopix_readout_ctrl.sv
// MONOPIX readout controller: per-channel token/read/shift sequencers feeding
// a round-robin arbiter and a Gray-decoded valid/ready hit stream.

module monopix_readout_ch #(
    parameter int WIDTH     = 27,
    parameter int TOKEN_DLY = 2,
    parameter int READ_LEN  = 1,
    parameter int DATA_LAT  = 2,
    parameter int SHIFT_LEN = 30
) (
    input  logic             clk_bx,
    input  logic             rst_n,
    input  logic             en,
    input  logic             token,
    input  logic             data_in,
    output logic             read,
    output logic             freeze,
    output logic             done,
    output logic [WIDTH-1:0] word
);
    localparam int CNT_W = $clog2(SHIFT_LEN + TOKEN_DLY + READ_LEN + 1);
    localparam int FIRST = DATA_LAT;
    localparam int LAST  = DATA_LAT + WIDTH - 1;

    typedef enum logic [1:0] {IDLE, TOKEN_WAIT, READ, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             token_q;
    logic             start;

    // token is registered once before the FSM acts on it
    assign start = en && token_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = TOKEN_WAIT;
            TOKEN_WAIT: if (cnt == CNT_W'(TOKEN_DLY - 1)) state_nxt = READ;
            READ:       if (cnt == CNT_W'(READ_LEN - 1)) state_nxt = SHIFT;
            SHIFT:      if (cnt == CNT_W'(SHIFT_LEN - 1)) state_nxt = start ? TOKEN_WAIT : IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_bx) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            token_q <= 1'b0;
            read    <= 1'b0;
            freeze  <= 1'b0;
            done    <= 1'b0;
            word    <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
            token_q <= token;
            read    <= (state == READ);
            freeze  <= (state == TOKEN_WAIT) || (state == READ);
            // word is complete after the last bit; the holding register takes it one edge later
            done    <= (state == SHIFT) && (cnt == CNT_W'(LAST));
            if (state == SHIFT && cnt >= CNT_W'(FIRST) && cnt <= CNT_W'(LAST))
                word <= {word[WIDTH-2:0], data_in};
        end
    end
endmodule

module monopix_readout_ctrl #(
    parameter int NCH       = 4,
    parameter int COL_W     = 6,
    parameter int ROW_W     = 9,
    parameter int TS_W      = 6,
    parameter int TOKEN_DLY = 2,
    parameter int READ_LEN  = 1,
    parameter int DATA_LAT  = 2,
    parameter int SHIFT_LEN = 30,
    localparam int WIDTH    = COL_W + ROW_W + 2 * TS_W,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_bx,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   token,
    input  logic [NCH-1:0]   data_in,
    output logic [NCH-1:0]   read,
    output logic [NCH-1:0]   freeze,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [COL_W-1:0] out_col,
    output logic [ROW_W-1:0] out_row,
    output logic [TS_W-1:0]  out_le,
    output logic [TS_W-1:0]  out_te,
    output logic [15:0]      lost_cnt
);
    if (SHIFT_LEN < DATA_LAT + WIDTH + 1) begin : g_bad_shift_len
        $error("SHIFT_LEN too short for DATA_LAT + WIDTH + 1");
    end

    logic [NCH-1:0]     done;
    logic [WIDTH-1:0]   word   [NCH];
    logic [NCH-1:0]     hold_v;
    logic [WIDTH-1:0]   hold_d [NCH];
    logic [CH_W-1:0]    last, gnt;
    logic               gnt_v, load;
    logic [NCH-1:0]     take;
    logic [2*NCH-1:0]   rot;
    logic [WIDTH-1:0]   sel;
    logic [16:0]        lost_sum;
    logic [15:0]        lost_nxt;
    int                 pos, s, ndrop;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        monopix_readout_ch #(
            .WIDTH(WIDTH), .TOKEN_DLY(TOKEN_DLY), .READ_LEN(READ_LEN),
            .DATA_LAT(DATA_LAT), .SHIFT_LEN(SHIFT_LEN)
        ) u_ch (
            .clk_bx (clk_bx),
            .rst_n  (rst_n),
            .en     (en[i]),
            .token  (token[i]),
            .data_in(data_in[i]),
            .read   (read[i]),
            .freeze (freeze[i]),
            .done   (done[i]),
            .word   (word[i])
        );
    end

    function automatic logic [TS_W-1:0] gray2bin(input logic [TS_W-1:0] g);
        logic [TS_W-1:0] b;
        b[TS_W-1] = g[TS_W-1];
        for (int k = TS_W - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    assign load = !out_valid || out_ready;

    // rotate occupancy so bit 0 is the channel right after the last grant
    always_comb begin
        rot   = {hold_v, hold_v} >> (int'(last) + 1);
        pos   = 0;
        gnt_v = |hold_v;
        for (int p = NCH - 1; p >= 0; p--) if (rot[p]) pos = p;
        s = int'(last) + 1 + pos;
        if (s >= NCH) s = s - NCH;
        gnt = CH_W'(s);
        sel = hold_d[gnt];
        take = '0;
        if (load && gnt_v) take[gnt] = 1'b1;
        ndrop = 0;
        for (int i = 0; i < NCH; i++) if (done[i] && hold_v[i] && !take[i]) ndrop++;
        lost_sum = {1'b0, lost_cnt} + 17'(ndrop);
        lost_nxt = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    end

    always_ff @(posedge clk_bx) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_le    <= '0;
            out_te    <= '0;
            lost_cnt  <= '0;
            last      <= CH_W'(NCH - 1);
            hold_v    <= '0;
            for (int i = 0; i < NCH; i++) hold_d[i] <= '0;
        end else begin
            if (load) begin
                out_valid <= gnt_v;
                if (gnt_v) begin
                    out_ch  <= gnt;
                    out_col <= sel[WIDTH-1 -: COL_W];
                    out_row <= sel[2*TS_W+ROW_W-1 -: ROW_W];
                    out_le  <= gray2bin(sel[2*TS_W-1 -: TS_W]);
                    out_te  <= gray2bin(sel[TS_W-1:0]);
                    last    <= gnt;
                end
            end
            // a slot freed by this edge's grant can take a word completing on the same edge
            for (int i = 0; i < NCH; i++) begin
                if (done[i] && (!hold_v[i] || take[i])) begin
                    hold_v[i] <= 1'b1;
                    hold_d[i] <= word[i];
                end else if (take[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
            lost_cnt <= lost_nxt;
        end
    end
endmodule

// File: tb/tb_monopix_readout_ctrl.sv
// Directed bench for monopix_readout_ctrl: a matrix model per channel shifts
// words out after each read strobe; a monitor logs handshakes and read pulses.

module tb_monopix_readout_ctrl;
    localparam int NCH = 4;
    localparam int W   = 27;
    localparam int DATA_LAT  = 2;
    localparam int SHIFT_LEN = 30;

    logic        clk_bx = 1'b0;
    logic        rst_n;
    logic        out_ready;
    logic [3:0]  en, token;
    wire  [3:0]  data_in;
    logic [3:0]  read, freeze;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [5:0]  out_col;
    logic [8:0]  out_row;
    logic [5:0]  out_le, out_te;
    logic [15:0] lost_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [28:0]  ent_q[$];
    int           ent_t[$];
    int           rd_t[$];
    logic [W-1:0] words [4][6];
    int           widx [4];
    logic         din_a [4];

    always #5 clk_bx = ~clk_bx;

    monopix_readout_ctrl dut (
        .clk_bx   (clk_bx),
        .rst_n    (rst_n),
        .en       (en),
        .token    (token),
        .data_in  (data_in),
        .read     (read),
        .freeze   (freeze),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_col  (out_col),
        .out_row  (out_row),
        .out_le   (out_le),
        .out_te   (out_te),
        .lost_cnt (lost_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_bx);
    endtask

    function automatic logic [W-1:0] mk(input int col, input int row, input logic [5:0] lg, input logic [5:0] tg);
        return {6'(col), 9'(row), lg, tg};
    endfunction

    function automatic logic [31:0] ex(input int ch, input int col, input int row, input int le, input int te);
        return 32'({2'(ch), 6'(col), 9'(row), 6'(le), 6'(te)});
    endfunction

    function automatic logic [31:0] ent(input int i);
        return (i < ent_q.size()) ? 32'(ent_q[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic int entt(input int i);
        return (i < ent_t.size()) ? ent_t[i] : -100;
    endfunction

    function automatic int rdt(input int i);
        return (i < rd_t.size()) ? rd_t[i] : -1000;
    endfunction

    // matrix model: after a read strobe, present one bit per cycle, MSB at dwell index DATA_LAT
    for (genvar g = 0; g < NCH; g++) begin : g_drv
        assign data_in[g] = din_a[g];
        initial begin
            logic [W-1:0] w;
            din_a[g] = 1'b0;
            widx[g]  = 0;
            forever begin
                @(negedge clk_bx);
                if (rst_n === 1'b1 && read[g] === 1'b1) begin
                    w = (widx[g] < 6) ? words[g][widx[g]] : '0;
                    widx[g]++;
                    for (int d = 0; d < SHIFT_LEN; d++) begin
                        din_a[g] = (d >= DATA_LAT && d < DATA_LAT + W) ? w[W-1-(d-DATA_LAT)] : 1'b0;
                        @(negedge clk_bx);
                    end
                    din_a[g] = 1'b0;
                end
            end
        end
    end

    // sample just before each rising edge, clear of both edges
    initial begin
        logic rd_q;
        rd_q = 1'b0;
        forever begin
            @(negedge clk_bx);
            #4;
            cyc++;
            if (out_valid && out_ready) begin
                ent_q.push_back({out_ch, out_col, out_row, out_le, out_te});
                ent_t.push_back(cyc);
            end
            if (read[0] && !rd_q) rd_t.push_back(cyc);
            rd_q = read[0];
        end
    end

    initial begin
        words[0][0] = mk(5, 100, 6'b000011, 6'b000110);
        words[0][1] = mk(20, 300, 6'b000011, 6'b000000);
        words[0][2] = mk(21, 301, 6'b000000, 6'b000011);
        words[0][3] = mk(22, 302, 6'b000000, 6'b000000);
        words[0][4] = mk(33, 33, 6'b000000, 6'b000000);
        words[0][5] = '0;
        words[1][0] = mk(1, 2, 6'b000111, 6'b000100);
        words[2][0] = mk(10, 200, 6'b000001, 6'b100000);
        words[3][0] = mk(63, 511, 6'b000000, 6'b000010);
        for (int c = 1; c < 4; c++) for (int k = 1; k < 6; k++) words[c][k] = '0;

        rst_n = 1'b0; en = 4'h0; token = 4'h0; out_ready = 1'b1;
        step(3);
        chk("rst_read",  32'(read), 32'h0);
        chk("rst_freeze", 32'(freeze), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_lost",  32'(lost_cnt), 32'h0);
        chk("rst_fields", 32'({out_ch, out_col, out_row, out_le, out_te}), 32'h0);

        // single frame on channel 0: token sampled at edge 0
        rst_n = 1'b1; en = 4'hF;
        step(2);
        token = 4'b0001;
        step(1);
        token = 4'b0000;
        chk("frz_e0", 32'(freeze), 32'h0);
        step(1);
        chk("frz_e1", 32'(freeze), 32'h0);
        step(1);
        chk("frz_e2", 32'(freeze), 32'h1);
        chk("rd_e2",  32'(read), 32'h0);
        step(1);
        chk("frz_e3", 32'(freeze), 32'h1);
        chk("rd_e3",  32'(read), 32'h0);
        step(1);
        chk("frz_e4", 32'(freeze), 32'h1);
        chk("rd_e4",  32'(read), 32'h1);
        step(1);
        chk("frz_e5", 32'(freeze), 32'h0);
        chk("rd_e5",  32'(read), 32'h0);
        step(40);
        chk("w0_count", 32'(ent_q.size()), 1);
        chk("w0_word",  ent(0), ex(0, 5, 100, 2, 4));

        // channel 2 sets the last grant, then 1 and 3 finish together
        token = 4'b0100;
        step(1);
        token = 4'b0000;
        step(44);
        token = 4'b1010;
        step(1);
        token = 4'b0000;
        step(44);
        chk("rr_count", 32'(ent_q.size()), 4);
        chk("rr_ch2",   ent(1), ex(2, 10, 200, 1, 63));
        chk("rr_first", ent(2), ex(3, 63, 511, 0, 3));
        chk("rr_second", ent(3), ex(1, 1, 2, 5, 7));
        chk("rr_consec", 32'(entt(3) - entt(2)), 32'h1);
        chk("rr_lost",  32'(lost_cnt), 32'h0);

        // stalled output, continuous token: three back-to-back frames on channel 0
        out_ready = 1'b0;
        rd_t.delete();
        token = 4'b0001;
        step(75);
        token = 4'b0000;
        step(40);
        chk("b2b_reads", 32'(rd_t.size()), 32'd3);
        chk("b2b_gap1",  32'(rdt(1) - rdt(0)), 32'd33);
        chk("b2b_gap2",  32'(rdt(2) - rdt(1)), 32'd33);
        chk("stall_valid", 32'(out_valid), 32'h1);
        chk("stall_word", 32'({out_ch, out_col, out_row, out_le, out_te}), ex(0, 20, 300, 2, 0));
        chk("stall_lost", 32'(lost_cnt), 32'h1);
        step(10);
        chk("stall_hold", 32'({out_ch, out_col, out_row, out_le, out_te}), ex(0, 20, 300, 2, 0));
        out_ready = 1'b1;
        step(6);
        chk("drain_count", 32'(ent_q.size()), 32'd6);
        chk("drain_a", ent(4), ex(0, 20, 300, 2, 0));
        chk("drain_b", ent(5), ex(0, 21, 301, 0, 2));
        chk("drain_valid", 32'(out_valid), 32'h0);

        // reset pulse in the middle of SHIFT
        token = 4'b0001;
        step(1);
        token = 4'b0000;
        step(15);
        rst_n = 1'b0;
        step(1);
        chk("mrst_read",   32'(read), 32'h0);
        chk("mrst_freeze", 32'(freeze), 32'h0);
        chk("mrst_valid",  32'(out_valid), 32'h0);
        chk("mrst_lost",   32'(lost_cnt), 32'h0);
        rst_n = 1'b1;
        step(45);
        chk("mrst_noword", 32'(ent_q.size()), 32'd6);

        // disabled channel ignores its token
        en = 4'b1101;
        token = 4'b0010;
        step(4);
        chk("dis_freeze", 32'(freeze), 32'h0);
        step(4);
        chk("dis_read", 32'(read), 32'h0);
        token = 4'b0000;
        step(2);
        en = 4'hF;
        step(45);
        chk("dis_noword", 32'(ent_q.size()), 32'd6);
        chk("end_lost", 32'(lost_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
